// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle control FSM and the MIPS32 datapath.
// The FSM is the master: it reads IR fields and status and drives enables and selects.
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       PC_wr;
  logic       IR_wr;
  logic [1:0] npc_sel;
  logic [1:0] ext_op;
  logic       B_sel;
  logic [2:0] alu_op;
  logic       dm_rd;
  logic       dm_wr;
  logic       gpr_wr;
  logic       gpr_dst;
  logic       wb_sel;
  logic       trap;
  logic [2:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output PC_wr, IR_wr, npc_sel, ext_op, B_sel, alu_op, dm_rd, dm_wr,
    output gpr_wr, gpr_dst, wb_sel, trap, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  PC_wr, IR_wr, npc_sel, ext_op, B_sel, alu_op, dm_rd, dm_wr,
    input  gpr_wr, gpr_dst, wb_sel, trap, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS32 control FSM: IF/ID/EXE/MEM/WB sequencing with a memory-ready
// wait counter and a sticky TRAP state for illegal opcodes or memory timeout.
module mc_ctrl_fsm #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  mc_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StExe  = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StTrap = 3'd7
  } state_e;

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpOri  = 6'h0D;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpLui  = 6'h0F;
  localparam logic [5:0] OpJ    = 6'h02;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  logic is_r, is_addu, is_subu, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, legal;

  assign is_r    = (bus.op == OpR);
  assign is_addu = is_r && (bus.funct == FnAddu);
  assign is_subu = is_r && (bus.funct == FnSubu);
  assign is_ori  = (bus.op == OpOri);
  assign is_lw   = (bus.op == OpLw);
  assign is_sw   = (bus.op == OpSw);
  assign is_beq  = (bus.op == OpBeq);
  assign is_lui  = (bus.op == OpLui);
  assign is_j    = (bus.op == OpJ);
  assign legal   = is_addu | is_subu | is_ori | is_lw | is_sw | is_beq | is_lui | is_j;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIf;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waiting = 1'b0;
    case (state_q)
      StIf: begin
        waiting = 1'b1;
        if (bus.mem_ready) state_d = StId;
      end
      StId: begin
        if (is_j)        state_d = StIf;
        else if (!legal) state_d = StTrap;
        else             state_d = StExe;
      end
      StExe: begin
        if (is_beq)              state_d = StIf;
        else if (is_lw || is_sw) state_d = StMem;
        else                     state_d = StWb;
      end
      StMem: begin
        waiting = 1'b1;
        if (bus.mem_ready) state_d = is_lw ? StWb : StIf;
      end
      StWb:    state_d = StIf;
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
    // A completing access on the last allowed cycle beats the timeout.
    if (waiting && !bus.mem_ready && (cnt_q == CW'(WAIT_MAX))) state_d = StTrap;
    if (state_d != state_q) cnt_d = '0;
    else if (waiting)       cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    bus.PC_wr   = 1'b0;
    bus.IR_wr   = 1'b0;
    bus.npc_sel = 2'b00;
    bus.ext_op  = 2'b00;
    bus.B_sel   = 1'b0;
    bus.alu_op  = 3'b000;
    bus.dm_rd   = 1'b0;
    bus.dm_wr   = 1'b0;
    bus.gpr_wr  = 1'b0;
    bus.gpr_dst = 1'b0;
    bus.wb_sel  = 1'b0;
    bus.trap    = (state_q == StTrap);
    bus.state   = state_q;
    // Gate enables on rst so nothing is written once reset rises.
    if (!rst) begin
      case (state_q)
        StIf: begin
          bus.PC_wr = bus.mem_ready;
          bus.IR_wr = bus.mem_ready;
        end
        StId: begin
          bus.B_sel = is_ori | is_lw | is_sw | is_lui;
          if (is_lw || is_sw || is_beq) bus.ext_op = 2'b01;
          else if (is_lui)              bus.ext_op = 2'b10;
          if (is_j) begin
            bus.PC_wr   = 1'b1;
            bus.npc_sel = 2'b10;
          end
        end
        StExe: begin
          if (is_subu || is_beq) bus.alu_op = 3'b001;
          else if (is_ori)       bus.alu_op = 3'b010;
          else if (is_lui)       bus.alu_op = 3'b011;
          if (is_beq) begin
            bus.PC_wr   = bus.zero;
            bus.npc_sel = 2'b01;
          end
        end
        StMem: begin
          bus.dm_rd = is_lw;
          bus.dm_wr = is_sw;
        end
        StWb: begin
          bus.gpr_wr  = 1'b1;
          bus.gpr_dst = is_r;
          bus.wb_sel  = is_lw;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed scenarios plus randomized instruction streams, all checked
// every cycle against a path-list model of the instruction sequencing.
module tb_mc_ctrl_fsm;
  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned CW       = 4;

  localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LW = 3, C_SW = 4;
  localparam int C_BEQ = 5, C_LUI = 6, C_J = 7, C_ILL = 8, C_ILLR = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_ctrl_fsm_if bus ();
  mc_ctrl_fsm #(.WAIT_MAX(WAIT_MAX), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  // Model: each class walks a fixed list of states; index, wait count and trap flag.
  int   m_idx = 0, m_wait = 0, m_cls = C_ADDU;
  bit   m_trap = 0;
  logic [5:0] cur_op = 6'h00, cur_funct = 6'h21;

  logic [18:0] lg [0:15];
  int lt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int plen(input int c);
    case (c)
      C_J, C_ILL, C_ILLR: return 2;
      C_BEQ:              return 3;
      C_LW:               return 5;
      default:            return 4;
    endcase
  endfunction

  function automatic int pstate(input int c, input int i);
    if (i < 3) return i;
    if (i == 3 && (c == C_LW || c == C_SW)) return 3;
    return 4;
  endfunction

  function automatic logic [18:0] expect_out(input int s, input int c, input logic z,
                                             input logic r);
    logic pc, ir, bs, rd, wr, gw, gd, wbs, tr;
    logic [1:0] npc, ext;
    logic [2:0] alu;
    {pc, ir, bs, rd, wr, gw, gd, wbs, tr} = '0;
    npc = 2'b00; ext = 2'b00; alu = 3'b000;
    if (s == 0) begin
      pc = r; ir = r;
    end else if (s == 1) begin
      bs  = (c == C_ORI || c == C_LW || c == C_SW || c == C_LUI);
      ext = (c == C_ORI) ? 2'b00 : (c == C_LW || c == C_SW || c == C_BEQ) ? 2'b01 :
            (c == C_LUI) ? 2'b10 : 2'b00;
      if (c == C_J) begin pc = 1'b1; npc = 2'b10; end
    end else if (s == 2) begin
      alu = (c == C_SUBU || c == C_BEQ) ? 3'b001 : (c == C_ORI) ? 3'b010 :
            (c == C_LUI) ? 3'b011 : 3'b000;
      if (c == C_BEQ) begin pc = z; npc = 2'b01; end
    end else if (s == 3) begin
      rd = (c == C_LW); wr = (c == C_SW);
    end else if (s == 4) begin
      gw = 1'b1; gd = (c == C_ADDU || c == C_SUBU); wbs = (c == C_LW);
    end else begin
      tr = 1'b1;
    end
    return {3'(s), tr, pc, ir, npc, ext, bs, alu, rd, wr, gw, gd, wbs};
  endfunction

  function automatic logic [18:0] dut_out();
    return {bus.state, bus.trap, bus.PC_wr, bus.IR_wr, bus.npc_sel, bus.ext_op, bus.B_sel,
            bus.alu_op, bus.dm_rd, bus.dm_wr, bus.gpr_wr, bus.gpr_dst, bus.wb_sel};
  endfunction

  task automatic pick(input int c, output logic [5:0] o, output logic [5:0] f);
    f = 6'($urandom_range(0, 63));
    case (c)
      C_ADDU: begin o = 6'h00; f = 6'h21; end
      C_SUBU: begin o = 6'h00; f = 6'h23; end
      C_ORI:  o = 6'h0D;
      C_LW:   o = 6'h23;
      C_SW:   o = 6'h2B;
      C_BEQ:  o = 6'h04;
      C_LUI:  o = 6'h0F;
      C_J:    o = 6'h02;
      C_ILL:  o = 6'h3F;
      default: begin o = 6'h00; f = 6'h20; end
    endcase
  endtask

  task automatic model_step(input logic r);
    int s;
    if (m_trap) return;
    s = pstate(m_cls, m_idx);
    if (s == 0 || s == 3) begin
      if (r) begin
        m_wait = 0; m_idx++;
      end else if (m_wait == int'(WAIT_MAX)) m_trap = 1;
      else m_wait++;
    end else if (s == 1 && m_cls >= C_ILL) begin
      m_trap = 1;
    end else begin
      m_wait = 0; m_idx++;
    end
    if (m_idx >= plen(m_cls)) m_idx = 0;
  endtask

  // Called at posedge+1; compares at the negedge, advances at the next posedge.
  task automatic tick(input int c, input logic z, input logic r);
    logic [5:0] o, f;
    logic [18:0] exp, got;
    if (m_idx == 0 && !m_trap) begin
      m_cls = c;
      pick(c, o, f);
      cur_op = o; cur_funct = f;
    end
    bus.op = cur_op; bus.funct = cur_funct; bus.zero = z; bus.mem_ready = r;
    @(negedge clk);
    exp = expect_out(m_trap ? 7 : pstate(m_cls, m_idx), m_cls, z, r);
    got = dut_out();
    if (lt < 16) lg[lt] = got;
    lt++;
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL cycle: got %h expected %h (model cls %0d idx %0d)", got, exp, m_cls,
                  m_idx);
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1 chk("rst_async_outputs", int'(dut_out()), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_idx = 0; m_wait = 0; m_trap = 0;
  endtask

  initial begin
    int cnt, burst, trap_len, c;
    logic r;
    rst = 1'b1;
    bus.op = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #3 chk("reset_outputs", int'(dut_out()), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // addu: IF ID EXE WB
    lt = 0;
    repeat (4) tick(C_ADDU, 1'b0, 1'b1);
    chk("addu_states", (int'(lg[0][18:16]) << 9) | (int'(lg[1][18:16]) << 6) |
        (int'(lg[2][18:16]) << 3) | int'(lg[3][18:16]), 'o0124);
    chk("addu_bsel_id", int'(lg[1][8]), 0);
    chk("addu_wb_gpr", int'(lg[3][2:1]), 3);
    chk("addu_back_if", int'(bus.state), 0);

    // lw with three stalled MEM cycles
    lt = 0;
    tick(C_LW, 1'b0, 1'b1); tick(C_LW, 1'b0, 1'b1); tick(C_LW, 1'b0, 1'b1);
    repeat (3) tick(C_LW, 1'b0, 1'b0);
    tick(C_LW, 1'b0, 1'b1); tick(C_LW, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 8; i++) cnt += int'(lg[i][4]);
    chk("lw_dm_rd_cycles", cnt, 4);
    chk("lw_wb_bits", int'(lg[7][2:0]), 3'b101);
    chk("lw_back_if", int'(bus.state), 0);

    // beq taken then not taken
    lt = 0;
    repeat (3) tick(C_BEQ, 1'b1, 1'b1);
    chk("beq_taken_pcwr_npc", int'(lg[2][14:11]), 4'b1001);
    lt = 0;
    repeat (3) tick(C_BEQ, 1'b0, 1'b1);
    chk("beq_not_taken_pcwr", int'(lg[2][14]), 0);
    chk("beq_back_if", int'(bus.state), 0);

    // j: two cycles
    repeat (2) tick(C_J, 1'b0, 1'b1);
    chk("j_back_if", int'(bus.state), 0);

    // illegal opcode traps and stays
    repeat (2) tick(C_ILL, 1'b0, 1'b1);
    repeat (20) tick(C_ADDU, 1'b1, 1'b1);
    chk("ill_state", int'(bus.state), 7);
    chk("ill_trap", int'(bus.trap), 1);
    pulse_rst();
    chk("ill_rst_trap", int'(bus.trap), 0);

    // fetch timeout, then ready on the last allowed cycle
    repeat (15) tick(C_ADDU, 1'b0, 1'b0);
    chk("timeout_pre", int'(bus.state), 0);
    tick(C_ADDU, 1'b0, 1'b0);
    chk("timeout_trap", int'(bus.state), 7);
    pulse_rst();
    repeat (15) tick(C_ADDU, 1'b0, 1'b0);
    tick(C_ADDU, 1'b0, 1'b1);
    chk("late_ready_id", int'(bus.state), 1);
    chk("late_ready_no_trap", int'(bus.trap), 0);
    repeat (3) tick(C_ADDU, 1'b0, 1'b1);

    // reset during sw MEM
    repeat (3) tick(C_SW, 1'b0, 1'b1);
    tick(C_SW, 1'b0, 1'b0);
    chk("sw_mem_dm_wr", int'(bus.dm_wr), 1);
    pulse_rst();
    repeat (3) tick(C_SW, 1'b0, 1'b0);
    tick(C_SW, 1'b0, 1'b1);

    // randomized streams
    burst = 0; trap_len = 0;
    for (int n = 0; n < 4000; n++) begin
      c = $urandom_range(0, 9);
      if (c >= C_ILL && $urandom_range(0, 3) != 0) c = $urandom_range(0, 7);
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(10, 20);
      if (burst > 0) begin
        r = 1'b0; burst--;
      end else r = ($urandom_range(0, 3) != 0);
      tick(c, 1'($urandom_range(0, 1)), r);
      trap_len = m_trap ? trap_len + 1 : 0;
      if (trap_len >= 20 || $urandom_range(0, 299) == 0) begin
        pulse_rst();
        trap_len = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
